pulse_channel_adsr: RTL
=======================

Name: pulse_channel_adsr

Overview:
Next-generation pulse voice for the synth datapath. It runs two phase-accumulator square oscillators (a primary and a shifted/detuned secondary) with a runtime duty-cycle compare. Both are gated by a full attack/decay/sustain/release envelope FSM stepped on tick_clk. Its output feeds the channel mixer exactly as the current single-envelope pulse voice does, but with parametrised widths and envelope rates.

Parameters:
PHASE_BITS, 18, oscillator accumulator width
AMP_BITS, 12, envelope amplitude width; audio_out is AMP_BITS+1
DUTY_BITS, 3, duty compare width (top DUTY_BITS of phase)
DETUNE, 2, constant added to secondary oscillator increment
CARRIER_SHIFT, 1, left shift of phase_inc for secondary oscillator
ATTACK_STEP, 12'h200, linear attack increment per tick
DECAY_SHIFT, 3, exponential decay shift toward sustain
SUSTAIN_LEVEL, 12'h400, sustain amplitude
RELEASE_SHIFT, 4, exponential release shift toward 0

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
sample_clk  in  1  one-cycle strobe; advance oscillators
tick_clk  in  1  one-cycle strobe; step envelope
song_clk  in  1  qualifies note_trigger
note_on  in  1  gate; low requests release
note_trigger  in  1  retrigger (effective only when song_clk && tick_clk)
phase_inc  in  PHASE_BITS  primary frequency increment
duty  in  DUTY_BITS  pulse width code
audio_out  out  AMP_BITS+1  summed oscillator output
env_state  out  3  envelope state encoding
active  out  1  high whenever env_state != IDLE

Behaviour:
- Reset (rst_n low at posedge clk): phase1 = 0, phase2 = 0, amplitude = 0, env_state = IDLE (0), audio_out = 0, active = 0.
- sample_clk and tick_clk are processed independently. Both can act in the same cycle; neither masks the other.
- Oscillators, on sample_clk:
  - phase1 += phase_inc, modulo 2^PHASE_BITS.
  - phase2 += (phase_inc << CARRIER_SHIFT) + DETUNE, truncated to PHASE_BITS.
- Gate: gateN = (phaseN[PHASE_BITS-1 -: DUTY_BITS] < duty).
  - duty = 0 gives a silent voice.
  - duty = 2^DUTY_BITS-1 gives a gate that is high for all but the top code.
- audio_out = (gate1 ? amp : 0) + (gate2 ? amp : 0). Combinational from registers; zero-extended; never overflows.
- Envelope FSM, stepped on tick_clk only. Encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
  - Trigger (song_clk && note_trigger) has highest priority in any state. It enters ATTACK and keeps the current amp, with no click to zero.
  - ATTACK: amp += ATTACK_STEP, saturating at all-ones. On reaching all-ones, go to DECAY.
  - DECAY: d = amp - SUSTAIN_LEVEL.
    - If d >> DECAY_SHIFT == 0: amp = SUSTAIN_LEVEL and go to SUSTAIN.
    - Otherwise amp -= d >> DECAY_SHIFT.
  - SUSTAIN: hold amp.
  - note_on low in ATTACK, DECAY or SUSTAIN (and no trigger) goes to RELEASE on that tick; amp is not stepped on that tick.
  - RELEASE: if amp >> RELEASE_SHIFT == 0, amp = 0 and go to IDLE; otherwise amp -= amp >> RELEASE_SHIFT.
  - RELEASE with note_on high and no trigger stays in RELEASE.
  - IDLE: amp = 0; only a trigger leaves IDLE.
- Latency: amp and env_state update on the clk edge where tick_clk is high. Oscillators update on the sample_clk edge.
- SUSTAIN_LEVEL must be less than 2^AMP_BITS-1. This is checked by an elaboration-time assertion.

Optional Feature:
PULSE_CHANNEL_SWEEP_EN. When defined:
- Adds input sweep_rate (signed, 8 bits) and an internal signed PHASE_BITS offset register.
- Each tick_clk: offset += sign-extended sweep_rate.
- A trigger clears offset to 0.
- The primary oscillator uses phase_inc + offset, clamped to [0, 2^PHASE_BITS-1]. The secondary oscillator derives from the same clamped value.

When not defined: no sweep_rate port and no offset register; behaviour is exactly as above.

Decomposition:
- Shared package synth_pkg holds the env_state enum (IDLE..RELEASE) and a default AMP_BITS constant, both shared with the mixer.
- Natural sub-module: pulse_osc (accumulator + duty compare, parametrised by increment shift/detune), instantiated twice.
- The envelope stays inline.

Test Plan:
- Reset mid-RELEASE (amp=0x300) -> next cycle amp=0, env_state=0, audio_out=0, phases 0.
- Trigger with note_on=1 from IDLE, defaults -> amp 0x200,0x400,...,0xE00,0xFFF (8 ticks; saturating on the 8th), then DECAY, converging to SUSTAIN with amp=0x400.
- In SUSTAIN, drop note_on -> RELEASE on next tick; amp decays 0x400->0x3C0->...; reaches IDLE with amp=0 when amp<16.
- phase_inc=0x1000, duty=4, amp=0x400 -> gate1 high for first half of period; audio_out in {0, 0x400, 0x800}; duty=0 -> audio_out constantly 0.
- Retrigger in RELEASE at amp=0x180 -> ATTACK, next amp=0x380.
- sample_clk and tick_clk asserted in the same cycle -> both phase and amp update on that edge.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg: types and defaults shared across the synth datapath
// (envelope state encoding and default amplitude width).
package synth_pkg;

  localparam int AMP_BITS_DEF = 12;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/pulse_channel_adsr_if.sv
// pulse_channel_adsr_if: control/strobe inputs and audio outputs of the voice.
// PULSE_CHANNEL_SWEEP_EN adds the signed sweep_rate input.
interface pulse_channel_adsr_if #(
  parameter int PHASE_BITS = 18,
  parameter int AMP_BITS   = synth_pkg::AMP_BITS_DEF,
  parameter int DUTY_BITS  = 3
);
  import synth_pkg::*;

  logic                  sample_clk;
  logic                  tick_clk;
  logic                  song_clk;
  logic                  note_on;
  logic                  note_trigger;
  logic [PHASE_BITS-1:0] phase_inc;
  logic [DUTY_BITS-1:0]  duty;
  logic [AMP_BITS:0]     audio_out;
  env_state_t            env_state;
  logic                  active;

`ifdef PULSE_CHANNEL_SWEEP_EN
  logic signed [7:0]     sweep_rate;

  modport master (
    output sample_clk, tick_clk, song_clk,
    output note_on, note_trigger,
    output phase_inc, duty, sweep_rate,
    input  audio_out, env_state, active
  );

  modport slave (
    input  sample_clk, tick_clk, song_clk,
    input  note_on, note_trigger,
    input  phase_inc, duty, sweep_rate,
    output audio_out, env_state, active
  );
`else
  modport master (
    output sample_clk, tick_clk, song_clk,
    output note_on, note_trigger,
    output phase_inc, duty,
    input  audio_out, env_state, active
  );

  modport slave (
    input  sample_clk, tick_clk, song_clk,
    input  note_on, note_trigger,
    input  phase_inc, duty,
    output audio_out, env_state, active
  );
`endif

endinterface

// File: rtl/pulse_osc.sv
// pulse_osc: phase accumulator with duty-cycle compare; the increment
// is the base increment shifted left by SHIFT plus DETUNE.
module pulse_osc #(
  parameter int PHASE_BITS = 18,
  parameter int DUTY_BITS  = 3,
  parameter int SHIFT      = 0,
  parameter int DETUNE     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PHASE_BITS-1:0] inc,
  input  logic [DUTY_BITS-1:0]  duty,
  output logic                  gate
);

  logic [PHASE_BITS-1:0] phase;
  logic [PHASE_BITS-1:0] step;

  assign step = (inc << SHIFT) + PHASE_BITS'(DETUNE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + step;
    end
  end

  assign gate = phase[PHASE_BITS-1 -: DUTY_BITS] < duty;

endmodule

// File: rtl/pulse_channel_adsr.sv
// pulse_channel_adsr: dual pulse oscillator voice gated by an ADSR envelope.
// Optional PULSE_CHANNEL_SWEEP_EN adds a per-tick frequency sweep offset.
module pulse_channel_adsr
  import synth_pkg::*;
#(
  parameter int                 PHASE_BITS    = 18,
  parameter int                 AMP_BITS      = AMP_BITS_DEF,
  parameter int                 DUTY_BITS     = 3,
  parameter int                 DETUNE        = 2,
  parameter int                 CARRIER_SHIFT = 1,
  parameter logic [AMP_BITS-1:0] ATTACK_STEP   = 'h200,
  parameter int                 DECAY_SHIFT   = 3,
  parameter logic [AMP_BITS-1:0] SUSTAIN_LEVEL = 'h400,
  parameter int                 RELEASE_SHIFT = 4
) (
  input logic                clk,
  input logic                rst_n,
  pulse_channel_adsr_if.slave bus
);

  localparam logic [AMP_BITS-1:0] AMP_MAX = '1;

  if (SUSTAIN_LEVEL >= AMP_MAX) begin : g_sustain_chk
    $error("SUSTAIN_LEVEL must be below full-scale amplitude");
  end

  env_state_t            state;
  logic [AMP_BITS-1:0]   amp;
  logic [PHASE_BITS-1:0] inc_eff;
  logic                  gate1;
  logic                  gate2;
  logic                  trig;
  logic [AMP_BITS:0]     att_sum;
  logic [AMP_BITS-1:0]   dec_step;
  logic [AMP_BITS-1:0]   rel_step;

  assign trig = bus.song_clk & bus.note_trigger;

`ifdef PULSE_CHANNEL_SWEEP_EN
  logic signed [PHASE_BITS-1:0] offset;
  logic signed [PHASE_BITS+1:0] inc_sum;

  assign inc_sum = $signed({2'b00, bus.phase_inc})
                 + $signed({{2{offset[PHASE_BITS-1]}}, offset});

  // Clamp the swept increment into the legal unsigned range.
  always_comb begin
    inc_eff = inc_sum[PHASE_BITS-1:0];
    if (inc_sum[PHASE_BITS+1]) begin
      inc_eff = '0;
    end else if (inc_sum[PHASE_BITS]) begin
      inc_eff = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset <= '0;
    end else if (bus.tick_clk) begin
      if (trig) begin
        offset <= '0;
      end else begin
        offset <= offset
          + {{(PHASE_BITS-8){bus.sweep_rate[7]}}, bus.sweep_rate};
      end
    end
  end
`else
  assign inc_eff = bus.phase_inc;
`endif

  pulse_osc #(
    .PHASE_BITS (PHASE_BITS),
    .DUTY_BITS  (DUTY_BITS),
    .SHIFT      (0),
    .DETUNE     (0)
  ) u_osc1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.sample_clk),
    .inc   (inc_eff),
    .duty  (bus.duty),
    .gate  (gate1)
  );

  pulse_osc #(
    .PHASE_BITS (PHASE_BITS),
    .DUTY_BITS  (DUTY_BITS),
    .SHIFT      (CARRIER_SHIFT),
    .DETUNE     (DETUNE)
  ) u_osc2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.sample_clk),
    .inc   (inc_eff),
    .duty  (bus.duty),
    .gate  (gate2)
  );

  assign att_sum  = {1'b0, amp} + {1'b0, ATTACK_STEP};
  assign dec_step = (amp - SUSTAIN_LEVEL) >> DECAY_SHIFT;
  assign rel_step = amp >> RELEASE_SHIFT;

  // Retrigger keeps the current amplitude so the attack starts click-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ENV_IDLE;
      amp   <= '0;
    end else if (bus.tick_clk) begin
      if (trig) begin
        state <= ENV_ATTACK;
      end else begin
        unique case (state)
          ENV_IDLE: begin
            amp <= '0;
          end
          ENV_ATTACK: begin
            if (!bus.note_on) begin
              state <= ENV_RELEASE;
            end else if (att_sum >= {1'b0, AMP_MAX}) begin
              amp   <= AMP_MAX;
              state <= ENV_DECAY;
            end else begin
              amp <= att_sum[AMP_BITS-1:0];
            end
          end
          ENV_DECAY: begin
            if (!bus.note_on) begin
              state <= ENV_RELEASE;
            end else if (dec_step == '0) begin
              amp   <= SUSTAIN_LEVEL;
              state <= ENV_SUSTAIN;
            end else begin
              amp <= amp - dec_step;
            end
          end
          ENV_SUSTAIN: begin
            if (!bus.note_on) begin
              state <= ENV_RELEASE;
            end
          end
          ENV_RELEASE: begin
            if (rel_step == '0) begin
              amp   <= '0;
              state <= ENV_IDLE;
            end else begin
              amp <= amp - rel_step;
            end
          end
          default: begin
            amp   <= '0;
            state <= ENV_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.env_state = state;
  assign bus.active    = (state != ENV_IDLE);
  assign bus.audio_out = (gate1 ? {1'b0, amp} : '0)
                       + (gate2 ? {1'b0, amp} : '0);

endmodule
